// File: rtl/pattern_game_engine.sv
// N-channel "repeat the sequence" memory game: grows a random pattern per level, plays it, checks presses.
// Optional WAIT inactivity timeout: define PATTERN_GAME_TIMEOUT_EN.
module pattern_game_engine #(
  parameter int NUM_CH       = 4,
  parameter int GAME_LIMIT   = 10,
  parameter int SHOW_CLKS    = 6250000,
  parameter int GAP_CLKS     = 6250000,
  parameter int TIMEOUT_CLKS = 75000000,
  parameter int ID_W         = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_press_dv,
  input  logic [ID_W-1:0]   i_press_id,
  input  logic [ID_W-1:0]   i_rand,
  output logic [NUM_CH-1:0] o_led,
  output logic [3:0]        o_score,
  output logic              o_busy,
  output logic              o_win,
  output logic              o_fail
);

  localparam int GAP_W  = $clog2(GAP_CLKS);
  localparam int SHOW_W = $clog2(SHOW_CLKS);
`ifdef PATTERN_GAME_TIMEOUT_EN
  localparam int TO_W   = $clog2(TIMEOUT_CLKS);
`else
  localparam int TO_W   = (TIMEOUT_CLKS > 0) ? 1 : 1;
`endif
  localparam int CNT_W0 = (GAP_W > SHOW_W) ? GAP_W : SHOW_W;
  localparam int CNT_W1 = (CNT_W0 > TO_W) ? CNT_W0 : TO_W;
  localparam int CNT_W  = (CNT_W1 < 1) ? 1 : CNT_W1;

  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CLKS - 1);
  localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(SHOW_CLKS - 1);
`ifdef PATTERN_GAME_TIMEOUT_EN
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CLKS - 1);
`endif
  localparam logic [3:0]        LIM       = 4'(GAME_LIMIT);
  localparam logic [ID_W:0]     NC_X      = (ID_W+1)'(NUM_CH);
  localparam logic [NUM_CH-1:0] LED_ONE   = NUM_CH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_GAP, S_SHOW, S_WAIT, S_LEVEL_UP, S_FAIL, S_WIN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        len_q, len_d, idx_q, idx_d, score_q, score_d, score_inc;
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              pat_we, tmr_clr, tmr_run;
  logic [ID_W:0]     rand_x;
  logic [ID_W-1:0]   rand_red;
  logic [ID_W-1:0]   pat_q [GAME_LIMIT];

  // Fold out-of-range random values back into 0..NUM_CH-1
  assign rand_x    = {1'b0, i_rand};
  assign rand_red  = (rand_x >= NC_X) ? ID_W'(rand_x - NC_X) : i_rand;
  assign score_inc = score_q + 4'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    pat_we  = 1'b0;
    tmr_clr = 1'b0;
    if (i_start) begin
      state_d = S_APPEND;
      len_d   = '0;
      idx_d   = '0;
      score_d = '0;
    end else begin
      case (state_q)
        S_APPEND: begin
          pat_we  = 1'b1;
          len_d   = len_q + 4'd1;
          idx_d   = '0;
          state_d = S_GAP;
        end
        S_GAP: if (tmr_q == GAP_LAST) state_d = S_SHOW;
        S_SHOW: if (tmr_q == SHOW_LAST) begin
          if (idx_q == len_q - 4'd1) begin
            state_d = S_WAIT;
            idx_d   = '0;
          end else begin
            state_d = S_GAP;
            idx_d   = idx_q + 4'd1;
          end
        end
        S_WAIT: begin
          if (i_press_dv) begin
            if (i_press_id == pat_q[idx_q]) begin
              if (idx_q == len_q - 4'd1) state_d = S_LEVEL_UP;
              else begin
                idx_d   = idx_q + 4'd1;
                tmr_clr = 1'b1;
              end
            end else begin
              state_d = S_FAIL;
            end
          end
`ifdef PATTERN_GAME_TIMEOUT_EN
          else if (tmr_q == TO_LAST) state_d = S_FAIL;
`endif
        end
        S_LEVEL_UP: begin
          score_d = score_inc;
          state_d = (score_inc == LIM) ? S_WIN : S_APPEND;
        end
        default: ; // IDLE, FAIL and WIN hold until i_start
      endcase
    end
  end

  // One shared timer; restarts on every state change
  always_comb begin
    tmr_run = (state_q == S_GAP) || (state_q == S_SHOW);
`ifdef PATTERN_GAME_TIMEOUT_EN
    tmr_run = tmr_run || (state_q == S_WAIT);
`endif
    tmr_d = (state_d != state_q || tmr_clr || !tmr_run) ? '0 : tmr_q + 1'b1;
  end

  always_comb begin
    led_d = '0;
    if (state_q == S_SHOW)     led_d = LED_ONE << pat_q[idx_q];
    else if (state_q == S_WIN) led_d = '1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      tmr_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (pat_we) pat_q[len_q] <= rand_red;
  end

  assign o_led   = led_q;
  assign o_busy  = (state_q == S_APPEND) || (state_q == S_GAP) || (state_q == S_SHOW);
  assign o_win   = (state_q == S_WIN);
  assign o_fail  = (state_q == S_FAIL);
  assign o_score = (state_q == S_FAIL) ? 4'hF : (state_q == S_WIN) ? 4'hE : score_q;

endmodule

// File: tb/tb_pattern_game_engine.sv
// Directed bench for pattern_game_engine: level flow, win, fail, ignored presses, restart, async reset.
module tb_pattern_game_engine;
  localparam int NC = 4, GL = 3, SC = 4, GC = 2, TO = 20;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start, dv;
  logic [1:0] id, rnd;
  logic [NC-1:0] led;
  logic [3:0] score;
  logic busy, win, fail;
  logic start3, dv3;
  logic [1:0] id3, rnd3;
  logic [2:0] led3;
  logic [3:0] score3;
  logic busy3, win3, fail3;
  int n_chk = 0, n_pass = 0;
  logic [31:0] shown;
  int on_cyc;
  logic [3:0] exp_led [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
  logic       exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  pattern_game_engine #(.NUM_CH(NC), .GAME_LIMIT(GL), .SHOW_CLKS(SC), .GAP_CLKS(GC),
                        .TIMEOUT_CLKS(TO)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_press_dv(dv), .i_press_id(id),
    .i_rand(rnd), .o_led(led), .o_score(score), .o_busy(busy), .o_win(win), .o_fail(fail));

  pattern_game_engine #(.NUM_CH(3), .GAME_LIMIT(GL), .SHOW_CLKS(SC), .GAP_CLKS(GC),
                        .TIMEOUT_CLKS(TO)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_press_dv(dv3), .i_press_id(id3),
    .i_rand(rnd3), .o_led(led3), .o_score(score3), .o_busy(busy3), .o_win(win3), .o_fail(fail3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go(input logic [1:0] r);
    start = 1'b1; rnd = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] p);
    dv = 1'b1; id = p;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_led(input int lim);
    int t = 0;
    while (led == '0 && t < lim) begin @(negedge clk); t++; end
    chk("wait_led", 32'(t < lim), 1);
  endtask

  // Play out one pattern: records each lit element and counts lit cycles until WAIT and dark
  task automatic run_show(output logic [31:0] sh, output int on);
    int t = 0;
    logic seen = 1'b0;
    sh = '0; on = 0;
    while (!busy && t < 8) begin @(negedge clk); t++; end
    t = 0;
    while (t < 400 && (busy || led != '0)) begin
      if (led != '0) begin
        if (!seen) sh = {sh[27:0], 4'(led)};
        on++;
      end
      seen = (led != '0);
      @(negedge clk); t++;
    end
    chk("show_end", 32'(t < 400), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 0; dv = 0; id = 0; rnd = 0;
    start3 = 0; dv3 = 0; id3 = 0; rnd3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win", win, 0);
    chk("rst_fail", fail, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Level 1: exact show timing
    go(2);
    for (int i = 0; i < 9; i++) begin
      chk("l1_led", led, exp_led[i]);
      chk("l1_busy", busy, exp_busy[i]);
      @(negedge clk);
    end
    rnd = 1;
    press(2);
    @(negedge clk);
    chk("l1_score", score, 1);
    run_show(shown, on_cyc);
    chk("l2_seq", shown, 32'h42);
    chk("l2_on", on_cyc, 8);
    rnd = 3;
    press(2); press(1);
    @(negedge clk);
    chk("l2_score", score, 2);
    run_show(shown, on_cyc);
    chk("l3_seq", shown, 32'h428);
    chk("l3_on", on_cyc, 12);
    press(2); press(1); press(3);
    @(negedge clk); @(negedge clk);
    chk("win_flag", win, 1);
    chk("win_score", score, 4'hE);
    chk("win_led", led, 4'hF);
    chk("win_busy", busy, 0);
    press(0);
    chk("win_hold", win, 1);

    // Wrong second press in level 2
    go(2);
    run_show(shown, on_cyc);
    rnd = 1;
    press(2);
    run_show(shown, on_cyc);
    press(2); press(3);
    chk("fail_flag", fail, 1);
    chk("fail_score", score, 4'hF);
    chk("fail_led", led, 0);
    chk("fail_win", win, 0);
    press(1); press(2);
    chk("fail_hold", fail, 1);
    chk("fail_hold_score", score, 4'hF);

    // Presses while the pattern plays are ignored
    go(2);
    run_show(shown, on_cyc);
    rnd = 1;
    press(2);
    wait_led(40);
    press(3); press(0);
    run_show(shown, on_cyc);
    chk("ign_seq", shown, 32'h42);
    chk("ign_fail", fail, 0);
    chk("ign_score", score, 1);
    // Start beats a simultaneous wrong press
    start = 1'b1; dv = 1'b1; id = 3; rnd = 0;
    @(negedge clk);
    start = 1'b0; dv = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_fail", fail, 0);
    chk("restart_busy", busy, 1);

    // NUM_CH=3: random 3 folds to 0, id 3 is always wrong
    start3 = 1'b1; rnd3 = 3;
    @(negedge clk);
    start3 = 1'b0;
    for (int t = 0; t < 20 && led3 == '0; t++) @(negedge clk);
    chk("ch3_led", led3, 3'b001);
    for (int t = 0; t < 20 && (busy3 || led3 != '0); t++) @(negedge clk);
    chk("ch3_wait", busy3, 0);
    dv3 = 1'b1; id3 = 3;
    @(negedge clk);
    dv3 = 1'b0;
    chk("ch3_fail", fail3, 1);
    chk("ch3_score", score3, 4'hF);
    chk("ch3_win", win3, 0);

    // Asynchronous reset in the middle of SHOW
    go(1);
    wait_led(40);
    chk("pre_rst_led", led, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led, 0);
    chk("arst_busy", busy, 0);
    chk("arst_score", score, 0);
    chk("arst_fail", fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef PATTERN_GAME_TIMEOUT_EN
    go(2);
    run_show(shown, on_cyc);
    repeat (18) @(negedge clk);
    chk("to_before", fail, 0);
    @(negedge clk);
    chk("to_expire", fail, 1);
    go(2);
    run_show(shown, on_cyc);
    rnd = 1;
    press(2);
    run_show(shown, on_cyc);
    repeat (18) @(negedge clk);
    press(2);
    chk("to_press_late", fail, 0);
    repeat (19) @(negedge clk);
    chk("to_cleared", fail, 0);
    @(negedge clk);
    chk("to_expire2", fail, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pattern_game_engine.md
Name: pattern_game_engine

Overview:
Parametrised successor to the single-board pattern-game logic: N-channel memory game ("repeat the sequence") with a growing, per-level random pattern and configurable show/gap timing. Sits between the debounced-button edge detector (one-cycle press pulses with ID) and the LED / 7-segment drivers. Pattern storage, timing counters and scoring are internal; randomness comes in on i_rand from an external LFSR.

Parameters:
NUM_CH, 4, number of buttons/LEDs (2..8); ID_W = $clog2(NUM_CH), minimum 1
GAME_LIMIT, 10, levels to win (1..15); pattern depth = GAME_LIMIT
SHOW_CLKS, 6250000, cycles each pattern element is lit
GAP_CLKS, 6250000, dark cycles before each element
TIMEOUT_CLKS, 75000000, max idle cycles in WAIT (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle start/restart pulse
i_press_dv  in  1  one-cycle pulse: button released, i_press_id valid
i_press_id  in  ID_W  index of released button
i_rand  in  ID_W  free-running random value, sampled in APPEND
o_led  out  NUM_CH  registered LED drive, one-hot while showing
o_score  out  4  completed levels; 4'hF on fail, 4'hE on win
o_busy  out  1  high while pattern is playing (GAP/SHOW/APPEND)
o_win  out  1  high while in WIN
o_fail  out  1  high while in FAIL

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low. Reset -> state IDLE, o_led=0, o_score=0, o_busy=0, o_win=0, o_fail=0, len=0, index=0, counters=0. Pattern RAM not reset.
- States: IDLE, APPEND, GAP, SHOW, WAIT, LEVEL_UP, FAIL, WIN.
- i_start in any state (highest priority, beats a simultaneous i_press_dv) -> APPEND; score=0, len=0, index=0.
- APPEND (1 cycle): pattern[len] <= (i_rand >= NUM_CH) ? i_rand-NUM_CH : i_rand; len<=len+1; index<=0 -> GAP. Earlier entries are kept, so the sequence grows by one element per level.
- GAP: exactly GAP_CLKS cycles, o_led=0 -> SHOW.
- SHOW: exactly SHOW_CLKS cycles with o_led = one-hot(pattern[index]) (registered; visible one cycle after state entry, exactly SHOW_CLKS cycles wide). At end: index==len-1 -> WAIT, index<=0; else index+1 -> GAP.
- Presses during APPEND/GAP/SHOW/LEVEL_UP are ignored.
- WAIT: o_led=0. On i_press_dv: id==pattern[index] -> if index==len-1 then LEVEL_UP else index+1. Wrong id (including id >= NUM_CH) -> FAIL.
- LEVEL_UP (1 cycle): score+1; new score==GAME_LIMIT -> WIN, else APPEND.
- FAIL: o_score=4'hF, o_fail=1, o_led=0; hold until i_start.
- WIN: o_score=4'hE, o_win=1, o_led=all-ones; hold until i_start.
- o_busy = state in {APPEND, GAP, SHOW}. Counter widths are $clog2 of their limits; counters clear on every state entry.

Optional Feature:
PATTERN_GAME_TIMEOUT_EN: defined -> WAIT counter clears on entry and on each correct press; reaching TIMEOUT_CLKS cycles without i_press_dv -> FAIL. A press arriving on the expiry cycle is evaluated normally and takes precedence. Undefined -> WAIT waits indefinitely; TIMEOUT_CLKS is unused and no counter is built.

Test Plan:
NUM_CH=4, GAME_LIMIT=3, SHOW_CLKS=4, GAP_CLKS=2, TIMEOUT_CLKS=20.
- Reset then i_start with i_rand=2 -> 2 dark cycles, then o_led=4'b0100 for exactly 4 cycles, then WAIT; o_busy high throughout and low in WAIT.
- Level 1 press id=2 -> o_score=1; i_rand=1 appended -> show 0100, gap, 0010; presses 2,1 -> o_score=2; third level correct -> o_win=1, o_score=4'hE, o_led=4'hF.
- Level 2 presses 2,3 -> FAIL on second press: o_fail=1, o_score=4'hF; later i_press_dv has no effect.
- Press pulses during SHOW -> ignored, no FAIL; same-cycle i_start and i_press_dv in WAIT -> restart, o_score=0.
- i_rand=3 with NUM_CH=3 -> stored element 0; i_press_id=3 in WAIT -> FAIL. Assert i_rst_n low mid-SHOW -> o_led=0 and IDLE immediately, without waiting for a clock edge.
- PATTERN_GAME_TIMEOUT_EN defined: no press for 20 cycles in WAIT -> FAIL; press on cycle 19 -> accepted, counter cleared.
